// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR writeback scheduler.
// Register index and data widths match the architectural register file
// (32 registers of 32 bits; register 0 is hard-wired and never written).
package gpr_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef logic [REG_W-1:0]  regidx_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage : gpr_pkg

// File: rtl/gpr_wb_sched_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// The grant goes to the first requester at or after the pointer, searching
// modulo N. The pointer moves just past the winner only when the caller
// says the grant was consumed (i_advance); otherwise it holds.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;

    // Search from the pointer for the first requester and compute the next pointer.
    always_comb begin
        o_gnt     = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
                w_found                        = 1'b1;
                o_gnt[(int'(r_ptr) + k) % N]   = 1'b1;
                if (((int'(r_ptr) + k) % N) == (N - 1)) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = PTR_W'(((int'(r_ptr) + k) % N) + 1);
                end
            end else begin
                w_found = w_found;
            end
        end
    end

    // Pointer register: restart at 0 on reset, step past each consumed grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule : rr_arbiter

// File: rtl/gpr_wb_sched.sv
// GPR writeback scheduler.
// Shares the single register-file write port among NREQ writeback sources
// with round-robin arbitration, registers the winning write (one cycle of
// latency), and keeps a per-register pending-write counter that issue logic
// queries for RAW hazards on rs/rt.
//
// Optional feature, macro GPR_FWD_EN: when defined, a query that hits the
// register being written this cycle, with exactly one write outstanding,
// raises *_fwd and masks *_busy so the consumer takes o_rd_data directly.
// With the macro undefined the *_fwd outputs are tied low.
module gpr_wb_sched
    import gpr_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    // issue side
    input  logic                   i_iss_valid,
    input  regidx_t                i_iss_dst,
    output logic                   o_iss_ready,
    // writeback sources
    input  logic [NREQ-1:0]        i_wb_req,
    input  logic [NREQ*REG_W-1:0]  i_wb_regf,
    input  logic [NREQ*DATA_W-1:0] i_wb_data,
    output logic [NREQ-1:0]        o_wb_gnt,
    // register file write port (index 0 = no write)
    output regidx_t                o_rd_regf,
    output data_t                  o_rd_data,
    // hazard queries
    input  regidx_t                i_rs_regf,
    input  regidx_t                i_rt_regf,
    output logic                   o_rs_busy,
    output logic                   o_rt_busy,
    output logic                   o_rs_fwd,
    output logic                   o_rt_fwd
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NREQ-1:0]  w_arb_gnt;
    logic             w_gnt_any;
    regidx_t          w_gnt_regf;
    data_t            w_gnt_data;

    regidx_t          r_rd_regf;
    data_t            r_rd_data;

    logic [CNT_W-1:0] r_cnt     [NREGS];
    logic [CNT_W-1:0] w_cnt_nxt [NREGS];

    logic             w_rs_pend;
    logic             w_rt_pend;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Every grant is consumed in the cycle it is given, so the pointer
    // advances whenever the arbiter grants outside of reset.
    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_wb_req),
        .i_advance (!rst),
        .o_gnt     (w_arb_gnt)
    );

    // Withdraw grants while reset is asserted.
    always_comb begin
        if (rst) begin
            o_wb_gnt = '0;
        end else begin
            o_wb_gnt = w_arb_gnt;
        end
    end

    // Select the destination and data of the granted source.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_regf = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (o_wb_gnt[i]) begin
                w_gnt_any  = 1'b1;
                w_gnt_regf = i_wb_regf[i*REG_W +: REG_W];
                w_gnt_data = i_wb_data[i*DATA_W +: DATA_W];
            end else begin
                w_gnt_any  = w_gnt_any;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write port register: one cycle after the grant.
    // ------------------------------------------------------------------
    // Capture the winning write; an idle cycle presents index 0 (no write).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_regf <= '0;
            r_rd_data <= '0;
        end else if (w_gnt_any) begin
            r_rd_regf <= w_gnt_regf;
            r_rd_data <= w_gnt_data;
        end else begin
            r_rd_regf <= '0;
            r_rd_data <= '0;
        end
    end

    assign o_rd_regf = r_rd_regf;
    assign o_rd_data = r_rd_data;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    // An issue to a saturated register is refused; register 0 never blocks.
    always_comb begin
        if ((i_iss_dst != REG_W'(0)) && (r_cnt[i_iss_dst] == CNT_MAX)) begin
            o_iss_ready = 1'b0;
        end else begin
            o_iss_ready = 1'b1;
        end
    end

    // Next counter values: issue increments, commit (o_rd_regf) decrements,
    // both together cancel, and a commit to an idle register is ignored.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (r == 0) begin
                w_cnt_nxt[r] = CNT_ZERO;
            end else if (i_iss_valid && o_iss_ready && (i_iss_dst == REG_W'(r))
                         && (r_rd_regf != REG_W'(r))) begin
                w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
            end else if ((r_rd_regf == REG_W'(r))
                         && !(i_iss_valid && o_iss_ready && (i_iss_dst == REG_W'(r)))
                         && (r_cnt[r] != CNT_ZERO)) begin
                w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
            end else begin
                w_cnt_nxt[r] = r_cnt[r];
            end
        end
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (rst) begin
                r_cnt[r] <= CNT_ZERO;
            end else begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard queries
    // ------------------------------------------------------------------
    // Busy means a write is still outstanding; with forwarding, the last
    // outstanding write appearing on the write port this cycle is usable.
    always_comb begin
        w_rs_pend = (i_rs_regf != REG_W'(0)) && (r_cnt[i_rs_regf] != CNT_ZERO);
        w_rt_pend = (i_rt_regf != REG_W'(0)) && (r_cnt[i_rt_regf] != CNT_ZERO);
`ifdef GPR_FWD_EN
        o_rs_fwd  = (i_rs_regf != REG_W'(0)) && (i_rs_regf == r_rd_regf)
                    && (r_cnt[i_rs_regf] == CNT_ONE);
        o_rt_fwd  = (i_rt_regf != REG_W'(0)) && (i_rt_regf == r_rd_regf)
                    && (r_cnt[i_rt_regf] == CNT_ONE);
`else
        o_rs_fwd  = 1'b0;
        o_rt_fwd  = 1'b0;
`endif
        o_rs_busy = w_rs_pend && !o_rs_fwd;
        o_rt_busy = w_rt_pend && !o_rt_fwd;
    end

endmodule : gpr_wb_sched

// File: tb/tb_gpr_wb_sched.sv
// Self-checking bench for gpr_wb_sched (NREQ=3, CNT_W=2).
// A behavioural model (counter array, pointer, one-entry write pipe) predicts
// every output each cycle; directed sequences and random traffic drive it.
module tb_gpr_wb_sched;

    localparam int NR   = 3;
    localparam int CMAX = 3;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_dst;
    logic        iss_ready;
    logic [2:0]  wb_req;
    logic [14:0] wb_regf;
    logic [95:0] wb_data;
    logic [2:0]  wb_gnt;
    logic [4:0]  rd_regf;
    logic [31:0] rd_data;
    logic [4:0]  rs_regf;
    logic [4:0]  rt_regf;
    logic        rs_busy;
    logic        rt_busy;
    logic        rs_fwd;
    logic        rt_fwd;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_cnt [32];
    int          m_ptr;
    logic [4:0]  m_rd_regf;
    logic [31:0] m_rd_data;
    bit          m_rd_dval;

    gpr_wb_sched #(.NREQ(3), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_iss_valid (iss_valid),
        .i_iss_dst   (iss_dst),
        .o_iss_ready (iss_ready),
        .i_wb_req    (wb_req),
        .i_wb_regf   (wb_regf),
        .i_wb_data   (wb_data),
        .o_wb_gnt    (wb_gnt),
        .o_rd_regf   (rd_regf),
        .o_rd_data   (rd_data),
        .i_rs_regf   (rs_regf),
        .i_rt_regf   (rt_regf),
        .o_rs_busy   (rs_busy),
        .o_rt_busy   (rt_busy),
        .o_rs_fwd    (rs_fwd),
        .o_rt_fwd    (rt_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected busy/fwd for one query index from the model.
    function automatic logic [1:0] query(input logic [4:0] q);
        logic fwd;
        logic pend;
        pend = (q != 5'd0) && (m_cnt[q] != 0);
`ifdef GPR_FWD_EN
        fwd  = (q != 5'd0) && (q == m_rd_regf) && (m_cnt[q] == 1);
`else
        fwd  = 1'b0;
`endif
        return {pend && !fwd, fwd};
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cyc(input bit r, input bit iv, input logic [4:0] dst,
                       input logic [2:0] req, input logic [14:0] rf,
                       input logic [95:0] dt, input logic [4:0] rs,
                       input logic [4:0] rt);
        int          g;
        int          idx;
        bit          rdy;
        logic [1:0]  qs;
        logic [1:0]  qt;
        logic [4:0]  n_regf;
        logic [31:0] n_data;
        rst = r; iss_valid = iv; iss_dst = dst; wb_req = req;
        wb_regf = rf; wb_data = dt; rs_regf = rs; rt_regf = rt;
        @(negedge clk);
        g = -1;
        if (!r) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && req[idx]) g = idx;
            end
        end
        rdy = !((dst != 5'd0) && (m_cnt[dst] == CMAX));
        qs  = query(rs);
        qt  = query(rt);
        chk("gnt", {29'd0, wb_gnt}, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, rdy});
        chk("rd_regf", {27'd0, rd_regf}, {27'd0, m_rd_regf});
        if (m_rd_dval) chk("rd_data", rd_data, m_rd_data);
        chk("rs_busy", {31'd0, rs_busy}, {31'd0, qs[1]});
        chk("rt_busy", {31'd0, rt_busy}, {31'd0, qt[1]});
        chk("rs_fwd", {31'd0, rs_fwd}, {31'd0, qs[0]});
        chk("rt_fwd", {31'd0, rt_fwd}, {31'd0, qt[0]});
        n_regf = (g >= 0) ? rf[g*5 +: 5] : 5'd0;
        n_data = (g >= 0) ? dt[g*32 +: 32] : 32'd0;
        @(posedge clk);
        #1;
        if (r) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ptr = 0; m_rd_regf = 5'd0; m_rd_data = 32'd0; m_rd_dval = 1'b1;
        end else begin
            for (int i = 1; i < 32; i++) begin
                bit inc;
                bit dec;
                inc = iv && rdy && (dst == 5'(i));
                dec = (m_rd_regf == 5'(i));
                if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
                else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
            if (g >= 0) m_ptr = (g + 1) % NR;
            m_rd_regf = n_regf; m_rd_data = n_data; m_rd_dval = (g >= 0);
        end
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        cyc(1'b0, 1'b0, 5'd0, 3'b000, 15'd0, 96'd0, rs, rt);
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ptr = 0; m_rd_regf = 5'd0; m_rd_data = 32'd0; m_rd_dval = 1'b1;
        rst = 1'b1; iss_valid = 1'b0; iss_dst = 5'd0; wb_req = 3'b000;
        wb_regf = 15'd0; wb_data = 96'd0; rs_regf = 5'd0; rt_regf = 5'd0;
        @(posedge clk);
        #1;
        // reset held with requests present: grants must stay low
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 1'b1, 5'd4, 3'b111, {5'd3, 5'd2, 5'd1}, 96'd0, 5'd4, 5'd0);
        // every index idle after reset
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // fairness: all three request continuously
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 5'd0, 3'b111, {5'd3, 5'd2, 5'd1},
                {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 5'd0, 5'd0);
            chk("fair_rd", {27'd0, rd_regf}, 32'(k % 3 + 1));
        end
        idle(5'd0, 5'd0);

        // RAW hazard on register 5
        cyc(1'b0, 1'b1, 5'd5, 3'b000, 15'd0, 96'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 3'b010, {5'd0, 5'd5, 5'd0},
            {32'd0, 32'hDEADBEEF, 32'd0}, 5'd5, 5'd5);
        chk("raw_rd", {27'd0, rd_regf}, 32'd5);
        chk("raw_data", rd_data, 32'hDEADBEEF);
        idle(5'd5, 5'd5);
        idle(5'd5, 5'd5);

        // saturation on register 7, then commit + issue in one cycle
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 5'd7, 3'b000, 15'd0, 96'd0, 5'd7, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h77}, 5'd7, 5'd0);
        cyc(1'b0, 1'b1, 5'd7, 3'b000, 15'd0, 96'd0, 5'd7, 5'd0);
        cyc(1'b0, 1'b1, 5'd7, 3'b000, 15'd0, 96'd0, 5'd7, 5'd0);
        // register 0: issue and write to index 0
        cyc(1'b0, 1'b1, 5'd0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 64'd0}, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // forwarding on register 9: single then double pending write
        cyc(1'b0, 1'b1, 5'd9, 3'b000, 15'd0, 96'd0, 5'd9, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'h99}, 5'd9, 5'd0);
        idle(5'd9, 5'd9);
        idle(5'd9, 5'd9);
        cyc(1'b0, 1'b1, 5'd9, 3'b000, 15'd0, 96'd0, 5'd9, 5'd0);
        cyc(1'b0, 1'b1, 5'd9, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h9A, 64'd0}, 5'd9, 5'd0);
        idle(5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // reset in the cycle after a grant
        cyc(1'b0, 1'b1, 5'd11, 3'b010, {5'd0, 5'd11, 5'd0}, {32'd0, 32'hB0B, 32'd0}, 5'd11, 5'd0);
        cyc(1'b1, 1'b0, 5'd0, 3'b110, {5'd11, 5'd11, 5'd0}, 96'd0, 5'd11, 5'd0);
        chk("rstmid_rd", {27'd0, rd_regf}, 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 3'b111, {5'd3, 5'd2, 5'd1}, 96'd0, 5'd11, 5'd9);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(9) < 7),
                5'($urandom_range(7)), 3'($urandom_range(7)),
                {5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7))},
                {$urandom, $urandom, $urandom},
                5'($urandom_range(7)), 5'($urandom_range(7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gpr_wb_sched
